// File: rtl/memory_io.sv
// Request/response types shared by every memory_io_req32 / memory_io_rsp32 port,
// plus the idle constants drivers use when nothing is outstanding.
package memory_io;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  do_read;
    logic [3:0]  do_write;
    logic [31:0] data;
  } memory_io_req32;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
  } memory_io_rsp32;

  // Payload carried through the responder's delay line alongside its valid bit.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        error;
  } memory_io_beat32;

  localparam memory_io_req32 memory_io_no_req = '0;
  localparam memory_io_rsp32 memory_io_no_rsp = '0;

endpackage

// File: rtl/memory_responder_pipe.sv
// DEPTH-stage valid/payload delay line with asynchronous clear; payload of an
// empty slot is held at zero so the last stage can drive an idle bus directly.
module memory_rsp_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_payload,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_payload
);

  logic             r_valid   [DEPTH];
  logic [WIDTH-1:0] r_payload [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_valid[i]   <= 1'b0;
        r_payload[i] <= '0;
      end
    end else begin
      r_valid[0]   <= i_valid;
      r_payload[0] <= i_valid ? i_payload : '0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_valid[i]   <= r_valid[i-1];
        r_payload[i] <= r_payload[i-1];
      end
    end
  end

  assign o_valid   = r_valid[DEPTH-1];
  assign o_payload = r_payload[DEPTH-1];

endmodule

// File: rtl/memory_responder.sv
// Word-organised SRAM responder: accepts one request per cycle, answers each
// after a fixed LATENCY with read data (read-old) or an out-of-range error.
module memory_responder
  import memory_io::*;
#(
  parameter int unsigned ADDR_BITS = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall_inject,
  input  memory_io_req32 req,
  output logic           req_ready,
  output memory_io_rsp32 rsp,
  output logic           rsp_error
);

  localparam int unsigned MEM_WORDS   = 1 << ADDR_BITS;
  localparam logic [31:0] RANGE_BYTES = 32'd4 << ADDR_BITS;

  logic [31:0]          r_mem [MEM_WORDS];

  logic                 w_accept;
  logic                 w_in_range;
  logic [31:0]          w_offset;
  logic [ADDR_BITS-1:0] w_idx;
  logic [31:0]          w_word;
  logic [31:0]          w_rdata;
  memory_io_beat32      w_beat;
  memory_io_beat32      w_out_beat;
  logic                 w_out_valid;

  assign req_ready  = !reset && !stall_inject;
  assign w_accept   = req.valid && req_ready;

  // Subtraction wraps for addresses below BASE_ADDR, so they fail the compare.
  assign w_offset   = req.addr - BASE_ADDR;
  assign w_in_range = w_offset < RANGE_BYTES;
  assign w_idx      = w_offset[ADDR_BITS+1:2];
  assign w_word     = r_mem[w_idx];

  always_comb begin
    w_rdata = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (req.do_read[i] && w_in_range) begin
        w_rdata[8*i +: 8] = w_word[8*i +: 8];
      end
    end
  end

  // Array contents survive reset; acceptance already excludes reset cycles.
  always_ff @(posedge clk) begin
    if (w_accept && w_in_range) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (req.do_write[i]) begin
          r_mem[w_idx][8*i +: 8] <= req.data[8*i +: 8];
        end
      end
    end
  end

  assign w_beat = '{addr: req.addr, data: w_rdata, error: !w_in_range};

  memory_rsp_pipe #(
    .DEPTH (LATENCY),
    .WIDTH ($bits(memory_io_beat32))
  ) u_pipe (
    .clk       (clk),
    .rst       (reset),
    .i_valid   (w_accept),
    .i_payload (w_beat),
    .o_valid   (w_out_valid),
    .o_payload (w_out_beat)
  );

  always_comb begin
    rsp       = memory_io_no_rsp;
    rsp.valid = w_out_valid;
    rsp.addr  = w_out_beat.addr;
    rsp.data  = w_out_beat.data;
    rsp_error = w_out_beat.error;
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: a queue-based reference predicts every
// cycle's outputs, and literal expectations pin the documented scenarios.
module tb_memory_responder;
  import memory_io::*;

  localparam int unsigned LAT = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           stall_inject = 1'b0;
  memory_io_req32 req = memory_io_no_req;
  logic           req_ready;
  memory_io_rsp32 rsp;
  logic           rsp_error;

  int checks   = 0;
  int failures = 0;

  memory_responder #(
    .ADDR_BITS (12),
    .BASE_ADDR (32'h0000_0000),
    .LATENCY   (LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_inject (stall_inject),
    .req          (req),
    .req_ready    (req_ready),
    .rsp          (rsp),
    .rsp_error    (rsp_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_mem [4096];
  int unsigned edge_n   = 0;
  int unsigned rsp_seen = 0;

  // Reference: a request seen at an edge is answered on the negedge that
  // follows edge (accept + LAT - 1), i.e. consumed at edge accept + LAT.
  always @(posedge clk) begin
    logic [31:0] off;
    logic [31:0] word;
    exp_t        x;
    edge_n++;
    if (!reset && !stall_inject && req.valid) begin
      off    = req.addr - 32'h0000_0000;
      x.addr = req.addr;
      x.due  = edge_n + LAT - 1;
      x.err  = (off >= 32'h0000_4000);
      x.data = 32'h0;
      if (!x.err) begin
        word = m_mem[off[13:2]];
        for (int b = 0; b < 4; b++) begin
          if (req.do_read[b])  x.data[8*b +: 8] = word[8*b +: 8];
          if (req.do_write[b]) word[8*b +: 8]   = req.data[8*b +: 8];
        end
        m_mem[off[13:2]] = word;
      end
      exp_q.push_back(x);
    end
  end

  always @(posedge reset) exp_q.delete();

  always @(negedge clk) begin
    logic        ev, ee, er;
    logic [31:0] ea, ed;
    exp_t        x;
    #1;
    ev = 1'b0; ea = 32'h0; ed = 32'h0; ee = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
      x  = exp_q.pop_front();
      ev = 1'b1; ea = x.addr; ed = x.data; ee = x.err;
    end
    er = !reset && !stall_inject;
    checks++;
    if (rsp.valid !== ev || rsp.addr !== ea || rsp.data !== ed ||
        rsp_error !== ee || req_ready !== er) begin
      failures++;
      $display("FAIL cycle%0d outputs: got v=%b a=%h d=%h err=%b rdy=%b, want v=%b a=%h d=%h err=%b rdy=%b",
               edge_n, rsp.valid, rsp.addr, rsp.data, rsp_error, req_ready,
               ev, ea, ed, ee, er);
    end
    if (rsp.valid) rsp_seen++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [3:0] rd,
                       input logic [3:0] wr, input logic [31:0] d);
    @(negedge clk);
    req.valid    = 1'b1;
    req.addr     = a;
    req.do_read  = rd;
    req.do_write = wr;
    req.data     = d;
  endtask

  task automatic quiet();
    @(negedge clk);
    req = memory_io_no_req;
  endtask

  // Waits (bounded) for the next response to address a; lat counts negedges.
  task automatic wait_rsp(input logic [31:0] a, output logic [31:0] d,
                          output logic e, output int lat);
    d = 32'h0; e = 1'b0; lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      req = memory_io_no_req;
      if (rsp.valid && rsp.addr == a) begin
        d = rsp.data; e = rsp_error; lat = k;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL wait_rsp timeout addr %h: got none want response", a);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    int unsigned n0;

    repeat (3) @(negedge clk);
    #2;
    check("reset_rsp_valid", {31'h0, rsp.valid}, 32'h0);
    check("reset_rsp_data", rsp.data, 32'h0);
    check("reset_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Preload word 3 then read it back with full mask.
    issue(32'h0C, 4'h0, 4'hF, 32'hDEAD_BEEF);
    wait_rsp(32'h0C, d, e, lat);
    check("t1_write_ack_data", d, 32'h0);
    issue(32'h0C, 4'hF, 4'h0, 32'h0);
    wait_rsp(32'h0C, d, e, lat);
    check("t1_read_data", d, 32'hDEAD_BEEF);
    check("t1_read_err", {31'h0, e}, 32'h0);
    check("t1_latency", lat, 32'd2);

    // Byte-enable write and masked read.
    issue(32'h14, 4'h0, 4'hF, 32'h1122_3344);
    wait_rsp(32'h14, d, e, lat);
    issue(32'h14, 4'h0, 4'b0101, 32'hAABB_CCDD);
    wait_rsp(32'h14, d, e, lat);
    issue(32'h14, 4'hF, 4'h0, 32'h0);
    wait_rsp(32'h14, d, e, lat);
    check("t2_merged_word", d, 32'h11BB_33DD);
    issue(32'h14, 4'b0011, 4'h0, 32'h0);
    wait_rsp(32'h14, d, e, lat);
    check("t2_masked_read", d, 32'h0000_33DD);

    // Back-to-back streaming of 8 writes then 8 reads.
    for (int i = 0; i < 8; i++)
      issue(32'(4 * i), 4'h0, 4'hF, 32'hA000_0000 + 32'(i) * 32'h0101);
    quiet();
    repeat (4) @(negedge clk);
    n0 = rsp_seen;
    for (int i = 0; i < 8; i++)
      issue(32'(4 * i), 4'hF, 4'h0, 32'h0);
    quiet();
    repeat (4) @(negedge clk);
    check("t3_stream_count", rsp_seen - n0, 32'd8);

    // Write followed next cycle by a read of the same word; then read+write.
    issue(32'h40, 4'h0, 4'hF, 32'h0000_0042);
    issue(32'h40, 4'hF, 4'h0, 32'h0);
    wait_rsp(32'h40, d, e, lat);
    check("t4_write_ack", d, 32'h0);
    wait_rsp(32'h40, d, e, lat);
    check("t4_hazard_read", d, 32'h0000_0042);
    issue(32'h40, 4'hF, 4'hF, 32'h0000_0099);
    wait_rsp(32'h40, d, e, lat);
    check("t4_read_old", d, 32'h0000_0042);
    issue(32'h40, 4'hF, 4'h0, 32'h0);
    wait_rsp(32'h40, d, e, lat);
    check("t4_after_rw", d, 32'h0000_0099);

    // Out-of-range read/write, plus the last in-range word.
    issue(32'h0000_4000, 4'hF, 4'h0, 32'h0);
    wait_rsp(32'h0000_4000, d, e, lat);
    check("t5_oor_data", d, 32'h0);
    check("t5_oor_err", {31'h0, e}, 32'h1);
    issue(32'h0000_4000, 4'h0, 4'hF, 32'hFFFF_FFFF);
    wait_rsp(32'h0000_4000, d, e, lat);
    check("t5_oor_write_err", {31'h0, e}, 32'h1);
    issue(32'h0, 4'hF, 4'h0, 32'h0);
    wait_rsp(32'h0, d, e, lat);
    check("t5_word0_intact", d, 32'hA000_0000);
    issue(32'h3FFC, 4'h0, 4'hF, 32'hCAFE_F00D);
    wait_rsp(32'h3FFC, d, e, lat);
    issue(32'h3FFC, 4'hF, 4'h0, 32'h0);
    wait_rsp(32'h3FFC, d, e, lat);
    check("t5_last_word", d, 32'hCAFE_F00D);
    check("t5_last_err", {31'h0, e}, 32'h0);

    // Stall with a request held valid: nothing accepted, nothing returned.
    @(negedge clk);
    n0 = rsp_seen;
    stall_inject = 1'b1;
    req.valid = 1'b1; req.addr = 32'h0C; req.do_read = 4'hF; req.do_write = 4'h0;
    repeat (3) begin
      #2;
      check("t6_stall_ready", {31'h0, req_ready}, 32'h0);
      @(negedge clk);
    end
    req = memory_io_no_req;
    stall_inject = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_stall_no_rsp", rsp_seen - n0, 32'd0);

    // Async reset with a write in flight: response dropped, write kept.
    issue(32'h80, 4'h0, 4'hF, 32'h5A5A_5A5A);
    @(posedge clk);
    #1;
    n0 = rsp_seen;
    reset = 1'b1;
    req.addr = 32'h80; req.do_read = 4'hF; req.do_write = 4'h0; req.data = 32'h0;
    #1;
    check("t7_reset_idle_valid", {31'h0, rsp.valid}, 32'h0);
    check("t7_reset_ready", {31'h0, req_ready}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    req = memory_io_no_req;
    repeat (3) @(negedge clk);
    check("t7_no_rsp_after_reset", rsp_seen - n0, 32'd0);
    issue(32'h80, 4'hF, 4'h0, 32'h0);
    wait_rsp(32'h80, d, e, lat);
    check("t7_write_kept", d, 32'h5A5A_5A5A);

    quiet();
    repeat (4) @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
